// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the parameterised accumulator CPU: default sizes,
// opcode encodings and FSM state encodings.
package acc_cpu_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_IMEM_AW = 5;
    localparam int unsigned DEF_DMEM_AW = 4;
    localparam int unsigned DEF_INSTR_W = 16;
    localparam int unsigned OPC_W       = 4;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_LDA = 4'h1;
    localparam opcode_t OP_ADD = 4'h2;
    localparam opcode_t OP_SUB = 4'h3;
    localparam opcode_t OP_AND = 4'h4;
    localparam opcode_t OP_OR  = 4'h5;
    localparam opcode_t OP_XOR = 4'h6;
    localparam opcode_t OP_STA = 4'h7;
    localparam opcode_t OP_JMP = 4'h8;
    localparam opcode_t OP_JZ  = 4'h9;
    localparam opcode_t OP_JN  = 4'hA;
    localparam opcode_t OP_OUT = 4'hB;
    localparam opcode_t OP_HLT = 4'hF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_FETCH   = 3'd1;
    localparam state_t ST_OPERAND = 3'd2;
    localparam state_t ST_EXEC    = 3'd3;
    localparam state_t ST_HALT    = 3'd4;

    // Opcodes whose ALU result is written back to the accumulator and flags.
    function automatic logic updates_flags(input opcode_t op);
        return op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU: result plus carry, signed
// overflow, negative and zero flags for the selected opcode.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  opcode_t           opcode,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              overflow,
    output logic              NO,
    output logic              ZO
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // SUB reports not-borrow in cout, so a >= b (unsigned) gives cout = 1.
    always_comb begin
        result   = a;
        cout     = 1'b0;
        overflow = 1'b0;
        case (opcode)
            OP_LDA: result = b;
            OP_ADD: begin
                result   = sum[DATA_W-1:0];
                cout     = sum[DATA_W];
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                result   = diff[DATA_W-1:0];
                cout     = ~diff[DATA_W];
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: ;
        endcase
    end

    assign NO = result[DATA_W-1];
    assign ZO = (result == '0);

endmodule

// File: rtl/acc_cpu_param.sv
// Parameterised accumulator CPU: three-cycle FETCH/OPERAND/EXEC sequencer with
// on-chip instruction and data register-array memories loadable while idle.
module acc_cpu_param
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned IMEM_AW = DEF_IMEM_AW,
    parameter int unsigned DMEM_AW = DEF_DMEM_AW,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load_instr,
    input  logic [IMEM_AW-1:0] load_instr_address,
    input  logic [INSTR_W-1:0] instruction_input,
    input  logic               load_data,
    input  logic [DMEM_AW-1:0] load_data_address,
    input  logic [DATA_W-1:0]  data_input,
    output logic               busy,
    output logic               halted,
    output logic [IMEM_AW-1:0] program_counter,
    output logic [DATA_W-1:0]  acc_value,
    output logic [DATA_W-1:0]  output_value,
    output logic               output_valid,
    output logic               cout,
    output logic               overflow,
    output logic               NO,
    output logic               ZO
);

    localparam int unsigned IMEM_DEPTH = 2 ** IMEM_AW;
    localparam int unsigned DMEM_DEPTH = 2 ** DMEM_AW;

    logic [INSTR_W-1:0] imem [IMEM_DEPTH];
    logic [DATA_W-1:0]  dmem [DMEM_DEPTH];

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] ir, ir_nxt;
    logic [DATA_W-1:0]  mdr, mdr_nxt;
    logic [IMEM_AW-1:0] pc_nxt;
    logic [DATA_W-1:0]  acc_nxt, out_value_nxt;
    logic               out_valid_nxt, busy_nxt, halted_nxt;
    logic               cout_nxt, ov_nxt, no_nxt, zo_nxt;
    logic               imem_we, dmem_load_we, dmem_sta_we;

    opcode_t            opcode;
    logic [IMEM_AW-1:0] operand_i;
    logic [DMEM_AW-1:0] operand_d;

    logic [DATA_W-1:0]  alu_result;
    logic               alu_cout, alu_ov, alu_no, alu_zo;

    // Instruction bits between operand and opcode are don't-care.
    logic               unused_ir;

    assign opcode    = ir[INSTR_W-1 -: OPC_W];
    assign operand_i = ir[IMEM_AW-1:0];
    assign operand_d = ir[DMEM_AW-1:0];
    assign unused_ir = ^ir;

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a        (acc_value),
        .b        (mdr),
        .opcode   (opcode),
        .result   (alu_result),
        .cout     (alu_cout),
        .overflow (alu_ov),
        .NO       (alu_no),
        .ZO       (alu_zo)
    );

    // Next-state and datapath control.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = program_counter;
        ir_nxt        = ir;
        mdr_nxt       = mdr;
        acc_nxt       = acc_value;
        out_value_nxt = output_value;
        out_valid_nxt = 1'b0;
        cout_nxt      = cout;
        ov_nxt        = overflow;
        no_nxt        = NO;
        zo_nxt        = ZO;
        imem_we       = 1'b0;
        dmem_load_we  = 1'b0;
        dmem_sta_we   = 1'b0;

        case (state)
            ST_IDLE, ST_HALT: begin
                imem_we      = load_instr;
                dmem_load_we = load_data;
                if (start) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = '0;
                    acc_nxt   = '0;
                    cout_nxt  = 1'b0;
                    ov_nxt    = 1'b0;
                    no_nxt    = 1'b0;
                    zo_nxt    = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_nxt    = imem[program_counter];
                pc_nxt    = program_counter + IMEM_AW'(1);
                state_nxt = ST_OPERAND;
            end
            ST_OPERAND: begin
                mdr_nxt   = dmem[operand_d];
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                if (updates_flags(opcode)) begin
                    acc_nxt  = alu_result;
                    cout_nxt = alu_cout;
                    ov_nxt   = alu_ov;
                    no_nxt   = alu_no;
                    zo_nxt   = alu_zo;
                end
                case (opcode)
                    OP_STA: dmem_sta_we = 1'b1;
                    OP_JMP: pc_nxt = operand_i;
                    OP_JZ:  if (ZO) pc_nxt = operand_i;
                    OP_JN:  if (NO) pc_nxt = operand_i;
                    OP_OUT: begin
                        out_value_nxt = acc_value;
                        out_valid_nxt = 1'b1;
                    end
                    OP_HLT: state_nxt = ST_HALT;
                    default: ;
                endcase
            end
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt   = (state_nxt == ST_FETCH) || (state_nxt == ST_OPERAND) || (state_nxt == ST_EXEC);
        halted_nxt = (state_nxt == ST_HALT);
    end

    // State and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            program_counter <= '0;
            ir              <= '0;
            mdr             <= '0;
            acc_value       <= '0;
            output_value    <= '0;
            output_valid    <= 1'b0;
            cout            <= 1'b0;
            overflow        <= 1'b0;
            NO              <= 1'b0;
            ZO              <= 1'b0;
            busy            <= 1'b0;
            halted          <= 1'b0;
        end else begin
            state           <= state_nxt;
            program_counter <= pc_nxt;
            ir              <= ir_nxt;
            mdr             <= mdr_nxt;
            acc_value       <= acc_nxt;
            output_value    <= out_value_nxt;
            output_valid    <= out_valid_nxt;
            cout            <= cout_nxt;
            overflow        <= ov_nxt;
            NO              <= no_nxt;
            ZO              <= zo_nxt;
            busy            <= busy_nxt;
            halted          <= halted_nxt;
        end
    end

    // Memories keep their contents across reset; reset only suppresses writes.
    always_ff @(posedge clk) begin
        if (!reset && imem_we) begin
            imem[load_instr_address] <= instruction_input;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (dmem_load_we) begin
                dmem[load_data_address] <= data_input;
            end else if (dmem_sta_we) begin
                dmem[operand_d] <= acc_value;
            end
        end
    end

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed self-checking bench for acc_cpu_param using small hand-assembled
// programs with hand-computed results.
module tb_acc_cpu_param;

    logic        clk;
    logic        reset;
    logic        start;
    logic        load_instr;
    logic [4:0]  load_instr_address;
    logic [15:0] instruction_input;
    logic        load_data;
    logic [3:0]  load_data_address;
    logic [15:0] data_input;
    logic        busy;
    logic        halted;
    logic [4:0]  program_counter;
    logic [15:0] acc_value;
    logic [15:0] output_value;
    logic        output_valid;
    logic        cout;
    logic        overflow;
    logic        NO;
    logic        ZO;

    int checks = 0;
    int errors = 0;

    int          cyc;
    int          pulses;
    logic [15:0] last_out;

    acc_cpu_param #(
        .DATA_W  (16),
        .IMEM_AW (5),
        .DMEM_AW (4),
        .INSTR_W (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .load_instr         (load_instr),
        .load_instr_address (load_instr_address),
        .instruction_input  (instruction_input),
        .load_data          (load_data),
        .load_data_address  (load_data_address),
        .data_input         (data_input),
        .busy               (busy),
        .halted             (halted),
        .program_counter    (program_counter),
        .acc_value          (acc_value),
        .output_value       (output_value),
        .output_valid       (output_valid),
        .cout               (cout),
        .overflow           (overflow),
        .NO                 (NO),
        .ZO                 (ZO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_i(input logic [4:0] addr, input logic [15:0] word);
        load_instr         = 1'b1;
        load_instr_address = addr;
        instruction_input  = word;
        tick();
        load_instr = 1'b0;
    endtask

    task automatic load_d(input logic [3:0] addr, input logic [15:0] val);
        load_data         = 1'b1;
        load_data_address = addr;
        data_input        = val;
        tick();
        load_data = 1'b0;
    endtask

    // Pulse start, then count cycles and OUT pulses until HALT or budget runs out.
    task automatic run_prog(input int max_cyc, output int n, output int np, output logic [15:0] lo);
        start = 1'b1;
        tick();
        start = 1'b0;
        n  = 0;
        np = 0;
        lo = '0;
        while (halted !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
            if (output_valid === 1'b1) begin
                np++;
                lo = output_value;
            end
        end
        check("halted_reached", 32'(halted), 32'd1);
    endtask

    function automatic logic [3:0] flags();
        return {cout, overflow, NO, ZO};
    endfunction

    initial begin
        reset              = 1'b1;
        start              = 1'b0;
        load_instr         = 1'b0;
        load_instr_address = '0;
        instruction_input  = '0;
        load_data          = 1'b0;
        load_data_address  = '0;
        data_input         = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_busy",   32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc",     32'(program_counter), 32'd0);
        check("rst_acc",    32'(acc_value), 32'd0);
        check("rst_flags",  32'(flags()), 32'd0);
        check("rst_outv",   32'(output_valid), 32'd0);
        check("rst_out",    32'(output_value), 32'd0);

        // 5 + 3, OUT, HLT
        load_d(4'd0, 16'h0005);
        load_d(4'd1, 16'h0003);
        load_i(5'd0, 16'h1000);
        load_i(5'd1, 16'h2001);
        load_i(5'd2, 16'hB000);
        load_i(5'd3, 16'hF000);
        run_prog(40, cyc, pulses, last_out);
        check("add_cycles", 32'(cyc), 32'd12);
        check("add_pulses", 32'(pulses), 32'd1);
        check("add_out",    32'(last_out), 32'h8);
        check("add_acc",    32'(acc_value), 32'h8);
        check("add_flags",  32'(flags()), 32'h0);
        check("add_busy",   32'(busy), 32'd0);
        check("add_outv",   32'(output_valid), 32'd0);

        // 0x7FFF + 1 signed overflow
        load_d(4'd0, 16'h7FFF);
        load_d(4'd1, 16'h0001);
        load_i(5'd2, 16'hF000);
        run_prog(40, cyc, pulses, last_out);
        check("ovf_cycles", 32'(cyc), 32'd9);
        check("ovf_acc",    32'(acc_value), 32'h8000);
        check("ovf_flags",  32'(flags()), 32'b0110);

        // 0xFFFF + 1 carry and zero, flags held through NOP and opcode C
        load_d(4'd0, 16'hFFFF);
        load_i(5'd2, 16'h0000);
        load_i(5'd3, 16'hC000);
        load_i(5'd4, 16'hF000);
        run_prog(40, cyc, pulses, last_out);
        check("carry_cycles", 32'(cyc), 32'd15);
        check("carry_acc",    32'(acc_value), 32'h0);
        check("carry_flags",  32'(flags()), 32'b1001);

        // OR after a carrying ADD clears cout
        load_i(5'd2, 16'h5001);
        load_i(5'd3, 16'hF000);
        run_prog(40, cyc, pulses, last_out);
        check("orclr_acc",   32'(acc_value), 32'h1);
        check("orclr_flags", 32'(flags()), 32'b0000);

        // 2 - 3 borrows
        load_d(4'd0, 16'h0002);
        load_d(4'd1, 16'h0003);
        load_i(5'd1, 16'h3001);
        load_i(5'd2, 16'hF000);
        run_prog(40, cyc, pulses, last_out);
        check("borrow_acc",   32'(acc_value), 32'hFFFF);
        check("borrow_flags", 32'(flags()), 32'b0010);

        // 0x8000 - 1 signed overflow, no borrow
        load_d(4'd0, 16'h8000);
        load_d(4'd1, 16'h0001);
        run_prog(40, cyc, pulses, last_out);
        check("subovf_acc",   32'(acc_value), 32'h7FFF);
        check("subovf_flags", 32'(flags()), 32'b1100);

        // AND / OR / XOR chain with OUT after each
        load_d(4'd0, 16'hF0F0);
        load_d(4'd1, 16'h0FF0);
        load_i(5'd1, 16'h4001);
        load_i(5'd2, 16'hB000);
        load_i(5'd3, 16'h5001);
        load_i(5'd4, 16'hB000);
        load_i(5'd5, 16'h6001);
        load_i(5'd6, 16'hB000);
        load_i(5'd7, 16'hF000);
        run_prog(60, cyc, pulses, last_out);
        check("logic_cycles", 32'(cyc), 32'd24);
        check("logic_pulses", 32'(pulses), 32'd3);
        check("logic_last",   32'(last_out), 32'h0);
        check("logic_flags",  32'(flags()), 32'b0001);

        // 3 - 3 then JZ taken over OUT to STA 2
        load_d(4'd0, 16'h0003);
        load_d(4'd1, 16'h0003);
        load_d(4'd2, 16'h55AA);
        load_i(5'd0, 16'h1000);
        load_i(5'd1, 16'h3001);
        load_i(5'd2, 16'h9005);
        load_i(5'd3, 16'hB000);
        load_i(5'd4, 16'hF000);
        load_i(5'd5, 16'h7002);
        load_i(5'd6, 16'hF000);
        run_prog(40, cyc, pulses, last_out);
        check("jz_cycles", 32'(cyc), 32'd15);
        check("jz_pulses", 32'(pulses), 32'd0);
        check("jz_pc",     32'(program_counter), 32'd7);
        check("jz_flags",  32'(flags()), 32'b1001);
        load_i(5'd0, 16'h1002);
        load_i(5'd1, 16'hB000);
        load_i(5'd2, 16'hF000);
        run_prog(40, cyc, pulses, last_out);
        check("jz_sta_pulses", 32'(pulses), 32'd1);
        check("jz_sta_val",    32'(last_out), 32'h0);

        // 2 - 3 then JN taken, STA stores 0xFFFF
        load_d(4'd0, 16'h0002);
        load_d(4'd1, 16'h0003);
        load_i(5'd0, 16'h1000);
        load_i(5'd1, 16'h3001);
        load_i(5'd2, 16'hA005);
        run_prog(40, cyc, pulses, last_out);
        check("jn_cycles", 32'(cyc), 32'd15);
        check("jn_pulses", 32'(pulses), 32'd0);
        load_i(5'd0, 16'h1002);
        load_i(5'd1, 16'hB000);
        load_i(5'd2, 16'hF000);
        run_prog(40, cyc, pulses, last_out);
        check("jn_sta_val", 32'(last_out), 32'hFFFF);

        // 3 - 1 then JN not taken, falls through to OUT
        load_d(4'd0, 16'h0003);
        load_d(4'd1, 16'h0001);
        load_i(5'd0, 16'h1000);
        load_i(5'd1, 16'h3001);
        load_i(5'd2, 16'hA005);
        run_prog(40, cyc, pulses, last_out);
        check("jnf_cycles", 32'(cyc), 32'd15);
        check("jnf_pulses", 32'(pulses), 32'd1);
        check("jnf_out",    32'(last_out), 32'h2);
        check("jnf_pc",     32'(program_counter), 32'd5);

        // All-NOP program: PC wraps, loads during the run are ignored
        load_d(4'd0, 16'h0005);
        load_d(4'd1, 16'h0003);
        for (int a = 0; a < 32; a++) load_i(5'(a), 16'h0000);
        start = 1'b1;
        tick();
        start  = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 93; i++) begin
            if (i == 10) begin
                load_instr         = 1'b1;
                load_instr_address = 5'd1;
                instruction_input  = 16'hB000;
                load_data          = 1'b1;
                load_data_address  = 4'd0;
                data_input         = 16'h1234;
            end
            tick();
            load_instr = 1'b0;
            load_data  = 1'b0;
            if (output_valid === 1'b1) pulses++;
        end
        check("wrap_pc31",  32'(program_counter), 32'd31);
        check("wrap_busy",  32'(busy), 32'd1);
        tick();
        check("wrap_pc0",   32'(program_counter), 32'd0);
        check("wrap_busy2", 32'(busy), 32'd1);
        check("wrap_halt",  32'(halted), 32'd0);
        check("wrap_pulses", 32'(pulses), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrap_rst_busy", 32'(busy), 32'd0);
        load_i(5'd4, 16'hF000);
        run_prog(40, cyc, pulses, last_out);
        check("imem_kept_cycles", 32'(cyc), 32'd15);
        check("imem_kept_pulses", 32'(pulses), 32'd0);

        // Start with a simultaneous load, then reset during ADD operand fetch
        load_i(5'd0, 16'h1000);
        load_i(5'd1, 16'h2001);
        load_i(5'd2, 16'hB000);
        start              = 1'b1;
        load_instr         = 1'b1;
        load_instr_address = 5'd3;
        instruction_input  = 16'hF000;
        tick();
        start      = 1'b0;
        load_instr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_acc",  32'(acc_value), 32'h5);
        check("mid_pc",   32'(program_counter), 32'd2);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_busy",   32'(busy), 32'd0);
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_acc",    32'(acc_value), 32'h0);
        check("rst2_pc",     32'(program_counter), 32'd0);
        check("rst2_flags",  32'(flags()), 32'h0);
        check("rst2_out",    32'(output_value), 32'h0);
        run_prog(40, cyc, pulses, last_out);
        check("rerun_cycles", 32'(cyc), 32'd12);
        check("rerun_pulses", 32'(pulses), 32'd1);
        check("rerun_out",    32'(last_out), 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
